iter_div_ctrl: RTL and testbench
================================

Name: iter_div_ctrl

Overview:
- Sequencer for a radix-2 restoring divider. All trial subtractions run through one shared add_with_Cout instance.
- Sits beside the ALU in the EXU. Accepts one divide/remainder op per valid/ready handshake and returns the result after a fixed iteration count.
- Handles RISC-V corner cases (divide-by-zero, signed overflow) without iterating.

Parameters:
- DATA_LEN, 64, operand/result width; also the iteration count.
- CNT_W, 7, counter width; must satisfy 2^CNT_W > DATA_LEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
- flush  in  1  abort the current op; return to IDLE next cycle
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept (high only in IDLE)
- dividend  in  DATA_LEN  operand A
- divisor  in  DATA_LEN  operand B
- is_signed  in  1  1 = two's-complement op
- want_rem  in  1  1 = return remainder, 0 = return quotient
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_LEN  quotient or remainder

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: DATA_LEN iterations.
  - FIX: sign correction.
  - DONE: out_valid=1, hold until accepted.
- Reset (rst_n=0 at a rising edge): state=IDLE, out_valid=0, result=0, counter=0, internal regs=0. Reset mid-operation discards the op; no result is produced.
- Accept: on in_valid & in_ready in cycle T, latch the operands, is_signed and want_rem.
- Signed ops: latch |dividend| and |divisor|; record q_neg = sign(A)^sign(B) and r_neg = sign(A).
- Special cases, decided at acceptance; next state is DONE (out_valid at T+1):
  - divisor==0: quotient = all ones, remainder = dividend.
  - is_signed, dividend = 1<<(DATA_LEN-1), divisor = all ones: quotient = dividend, remainder = 0.
- Normal path:
  - CALC for cycles T+1..T+DATA_LEN, counter counting DATA_LEN-1 down to 0.
  - Each cycle: trial = {rem[DATA_LEN-2:0], quo[DATA_LEN-1]}. Adder computes trial + ~divisor + 1 (OP_A=trial, OP_B=divisor, Cin=1).
  - Cout=1 (no borrow): rem <= Sum, shift in quotient bit 1. Otherwise rem <= trial, shift in 0.
  - Quotient shifts left through the quo register, which initially holds the dividend.
- FIX at T+DATA_LEN+1: negate the quotient if q_neg, negate the remainder if r_neg (signed only). Select by want_rem into result.
- out_valid rises at T+DATA_LEN+2. Normal latency is DATA_LEN+2 cycles accept-to-valid.
- DONE: result is stable while out_valid & !out_ready. On out_valid & out_ready, go to IDLE next cycle and clear out_valid.
- No same-cycle re-accept in DONE: in_ready=0 in DONE.
- flush:
  - In CALC, FIX or DONE: go to IDLE next cycle, out_valid=0, result unchanged.
  - In IDLE: in_ready still reads 1, but a coincident in_valid is dropped.
  - flush has priority over accept and over out_ready.
- Adder overflow output is unused. Unsigned ops never negate.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

Decomposition:
- Shared constants in define.v:
  - Four state encodings: DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE.
  - DIV_BY_ZERO_Q (all ones).
- Sub-module: the existing add_with_Cout (DATA_LEN passed through) for the trial subtraction. No other sub-modules.
- Negation in FIX is a local two's-complement expression.

Test Plan:
- Unsigned 100 / 7, want_rem=0: result 14, out_valid exactly 66 cycles after accept (DATA_LEN=64). Same operands with want_rem=1: result 2.
- Signed -7 / 2: quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1. Signed 7 / -2: quotient -3, remainder 1.
- divisor=0, dividend=0x1234: quotient all ones, remainder 0x1234, out_valid at T+1. Signed MIN / -1: quotient 0x8000_0000_0000_0000, remainder 0, out_valid at T+1.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles after valid: result and out_valid stable, in_ready=0.
  - Raise out_ready: IDLE next cycle. Back-to-back second op accepted the cycle in_ready returns.
- Assert flush at iteration 30: IDLE next cycle, no out_valid. Then issue 0xFFFF_FFFF_FFFF_FFFF / 3 unsigned: quotient 0x5555_5555_5555_5555.
- Drop rst_n for one cycle mid-CALC: out_valid=0, result=0, in_ready=1 after the edge. A following op completes correctly.

Source files
------------

// File: rtl/iter_div_ctrl_pkg.sv
// Shared state encodings and constants for the radix-2 restoring divide sequencer.
package iter_div_ctrl_pkg;

   localparam int DIV_DATA_LEN_DEF = 64;
   localparam int DIV_CNT_W_DEF    = 7;
   localparam int DIV_MAX_LEN      = 128;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Quotient returned for a zero divisor; sliced down to the operand width by users.
   localparam logic [DIV_MAX_LEN-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/add_with_Cout.sv
// Ripple-carry adder with carry-out and signed overflow flag.
module add_with_Cout #(
   parameter int DATA_LEN = 64
) (
   input  logic [DATA_LEN-1:0] op_a,
   input  logic [DATA_LEN-1:0] op_b,
   input  logic                cin,
   output logic [DATA_LEN-1:0] sum,
   output logic                cout,
   output logic                overflow
);

   logic [DATA_LEN:0] carry;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_bit
      assign sum[gi]      = op_a[gi] ^ op_b[gi] ^ carry[gi];
      assign carry[gi+1]  = (op_a[gi] & op_b[gi]) | (op_a[gi] & carry[gi]) | (op_b[gi] & carry[gi]);
   end

   assign cout     = carry[DATA_LEN];
   assign overflow = carry[DATA_LEN] ^ carry[DATA_LEN-1];

endmodule

// File: rtl/iter_div_ctrl.sv
// Radix-2 restoring divide/remainder sequencer; trial subtractions share one adder.
module iter_div_ctrl
   import iter_div_ctrl_pkg::*;
#(
   parameter int DATA_LEN = DIV_DATA_LEN_DEF,
   parameter int CNT_W    = DIV_CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] dividend,
   input  logic [DATA_LEN-1:0] divisor,
   input  logic                is_signed,
   input  logic                want_rem,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] result
);

   localparam logic [DATA_LEN-1:0] MIN_VAL = {1'b1, {(DATA_LEN-1){1'b0}}};
   localparam logic [DATA_LEN-1:0] ZERO_Q  = DIV_BY_ZERO_Q[DATA_LEN-1:0];
   localparam logic [CNT_W-1:0]    CNT_TOP = CNT_W'(DATA_LEN - 1);

   div_state_e          state_reg, state_next;
   logic [DATA_LEN-1:0] quo_reg, quo_next;
   logic [DATA_LEN-1:0] rem_reg, rem_next;
   logic [DATA_LEN-1:0] div_reg, div_next;
   logic [DATA_LEN-1:0] result_reg, result_next;
   logic [CNT_W-1:0]    counter_reg, counter_next;
   logic                q_neg_reg, q_neg_next;
   logic                r_neg_reg, r_neg_next;
   logic                want_rem_reg, want_rem_next;

   logic [DATA_LEN-1:0] trial;
   logic [DATA_LEN-1:0] add_sum;
   logic                add_cout;
   logic [DATA_LEN-1:0] dividend_abs;
   logic [DATA_LEN-1:0] divisor_abs;
   logic [DATA_LEN-1:0] quo_fixed;
   logic [DATA_LEN-1:0] rem_fixed;

   assign trial = {rem_reg[DATA_LEN-2:0], quo_reg[DATA_LEN-1]};

   // Subtraction as trial + ~divisor + 1; a carry-out means no borrow.
   add_with_Cout #(
      .DATA_LEN (DATA_LEN)
   ) u_add (
      .op_a     (trial),
      .op_b     (~div_reg),
      .cin      (1'b1),
      .sum      (add_sum),
      .cout     (add_cout),
      .overflow ()
   );

   assign dividend_abs = (is_signed && dividend[DATA_LEN-1]) ? -dividend : dividend;
   assign divisor_abs  = (is_signed && divisor[DATA_LEN-1])  ? -divisor  : divisor;
   assign quo_fixed    = q_neg_reg ? -quo_reg : quo_reg;
   assign rem_fixed    = r_neg_reg ? -rem_reg : rem_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= DIV_IDLE;
         quo_reg      <= '0;
         rem_reg      <= '0;
         div_reg      <= '0;
         result_reg   <= '0;
         counter_reg  <= '0;
         q_neg_reg    <= 1'b0;
         r_neg_reg    <= 1'b0;
         want_rem_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         quo_reg      <= quo_next;
         rem_reg      <= rem_next;
         div_reg      <= div_next;
         result_reg   <= result_next;
         counter_reg  <= counter_next;
         q_neg_reg    <= q_neg_next;
         r_neg_reg    <= r_neg_next;
         want_rem_reg <= want_rem_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      quo_next      = quo_reg;
      rem_next      = rem_reg;
      div_next      = div_reg;
      result_next   = result_reg;
      counter_next  = counter_reg;
      q_neg_next    = q_neg_reg;
      r_neg_next    = r_neg_reg;
      want_rem_next = want_rem_reg;

      case (state_reg)
         DIV_IDLE: begin
            if (in_valid && !flush) begin
               quo_next      = dividend_abs;
               rem_next      = '0;
               div_next      = divisor_abs;
               want_rem_next = want_rem;
               q_neg_next    = is_signed && (dividend[DATA_LEN-1] ^ divisor[DATA_LEN-1]);
               r_neg_next    = is_signed && dividend[DATA_LEN-1];
               counter_next  = CNT_TOP;
               if (divisor == '0) begin
                  result_next = want_rem ? dividend : ZERO_Q;
                  state_next  = DIV_DONE;
               end else if (is_signed && dividend == MIN_VAL && divisor == '1) begin
                  result_next = want_rem ? '0 : dividend;
                  state_next  = DIV_DONE;
               end else begin
                  state_next  = DIV_CALC;
               end
            end
         end

         DIV_CALC: begin
            if (flush) begin
               state_next = DIV_IDLE;
            end else begin
               rem_next = add_cout ? add_sum : trial;
               quo_next = {quo_reg[DATA_LEN-2:0], add_cout};
               if (counter_reg == '0) begin
                  state_next = DIV_FIX;
               end else begin
                  counter_next = counter_reg - 1'b1;
               end
            end
         end

         DIV_FIX: begin
            if (flush) begin
               state_next = DIV_IDLE;
            end else begin
               result_next = want_rem_reg ? rem_fixed : quo_fixed;
               state_next  = DIV_DONE;
            end
         end

         DIV_DONE: begin
            if (flush || out_ready) begin
               state_next = DIV_IDLE;
            end
         end

         default: state_next = DIV_IDLE;
      endcase
   end

   // Handshake outputs depend on the state register only.
   assign in_ready  = (state_reg == DIV_IDLE);
   assign out_valid = (state_reg == DIV_DONE);
   assign result    = result_reg;

endmodule

// File: tb/tb_iter_div_ctrl.sv
// Self-checking bench for iter_div_ctrl: directed corner cases then randomized ops vs an arithmetic model.
module tb_iter_div_ctrl;

   localparam int N   = 64;
   localparam int LAT = N + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         is_signed = 1'b0;
   logic         want_rem = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iter_div_ctrl #(.DATA_LEN(N), .CNT_W(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .is_signed (is_signed),
      .want_rem  (want_rem),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   function automatic logic [N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic sgn, input logic wr);
      logic signed [N-1:0] sa, sb;
      logic [N-1:0] min_v;
      min_v = {1'b1, {(N-1){1'b0}}};
      sa = a;
      sb = b;
      if (b == '0) return wr ? a : '1;
      if (sgn) begin
         if (a == min_v && b == '1) return wr ? '0 : a;
         return wr ? (sa % sb) : (sa / sb);
      end
      return wr ? (a % b) : (a / b);
   endfunction

   function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn);
      if (b == '0) return 1;
      if (sgn && a == {1'b1, {(N-1){1'b0}}} && b == '1) return 1;
      return LAT;
   endfunction

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where out_valid is seen (or the bound expires).
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn,
                         input logic wr, output logic [N-1:0] res, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      dividend  = a;
      divisor   = b;
      is_signed = sgn;
      want_rem  = wr;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      res = result;
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
      chk({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   task automatic op_expect(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic sgn, input logic wr, input logic [N-1:0] exp, input int exp_lat);
      logic [N-1:0] res;
      int lat;
      run_op(a, b, sgn, wr, res, lat);
      $display("op %s: a=%h b=%h s=%0d rem=%0d -> %h after %0d cycles", tag, a, b, sgn, wr, res, lat);
      chk({tag, "_res"}, res, exp);
      chk({tag, "_lat"}, N'(lat), N'(exp_lat));
      release_out(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] res, first_res, a, b;
      logic sgn, wr;
      int lat, seen, sel;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result", result, 64'd0);

      // Basic unsigned and signed ops
      op_expect("u100_7_q", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, LAT);
      op_expect("u100_7_r", 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, LAT);
      op_expect("s-7_2_q", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, LAT);
      op_expect("s-7_2_r", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, LAT);
      op_expect("s7_-2_q", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, LAT);
      op_expect("s7_-2_r", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 64'd1, LAT);
      op_expect("u7_-2_q", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64'd0, LAT);

      // Corner cases resolved at acceptance
      op_expect("div0_q", 64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      op_expect("div0_r", 64'h1234, 64'd0, 1'b0, 1'b1, 64'h1234, 1);
      op_expect("sdiv0_r", 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1);
      op_expect("ovf_q", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                64'h8000_0000_0000_0000, 1);
      op_expect("ovf_r", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'd0, 1);
      op_expect("umin_ff_q", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, LAT);

      // Back-pressure then back-to-back op
      run_op(64'd1000, 64'd9, 1'b0, 1'b0, first_res, lat);
      chk("bp_res", first_res, 64'd111);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_res", result, 64'd111);
         chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      end
      release_out("bp");
      op_expect("bp_b2b", 64'd1000, 64'd9, 1'b0, 1'b1, 64'd1, LAT);

      // Flush mid-CALC
      dividend = 64'd500; divisor = 64'd3; is_signed = 1'b0; want_rem = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (29) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", {63'd0, in_ready}, 64'd1);
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_result_kept", result, 64'd1);
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("flush_no_valid", N'(seen), 64'd0);
      op_expect("all1_3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 64'h5555_5555_5555_5555, LAT);

      // Flush in IDLE drops a coincident request
      dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_ready", {63'd0, in_ready}, 64'd1);
      chk("idle_flush_valid", {63'd0, out_valid}, 64'd0);

      // Reset mid-CALC
      dividend = 64'd12345; divisor = 64'd10; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_result", result, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      op_expect("post_rst", 64'd12345, 64'd10, 1'b0, 1'b1, 64'd5, LAT);

      // Randomized ops against the arithmetic model
      for (int k = 0; k < 30; k++) begin
         a   = {$urandom, $urandom};
         sel = $urandom_range(0, 5);
         case (sel)
            0: b = 64'd0;
            1: b = N'($urandom_range(1, 20));
            2: b = {$urandom, $urandom};
            3: b = {32'd0, $urandom};
            4: b = -N'($urandom_range(1, 20));
            default: begin
               a = 64'h8000_0000_0000_0000;
               b = 64'hFFFF_FFFF_FFFF_FFFF;
            end
         endcase
         sgn = 1'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         run_op(a, b, sgn, wr, res, lat);
         $display("rnd %0d: a=%h b=%h s=%0d rem=%0d -> %h after %0d cycles", k, a, b, sgn, wr, res, lat);
         chk("rnd_res", res, ref_div(a, b, sgn, wr));
         chk("rnd_lat", N'(lat), N'(ref_lat(a, b, sgn)));
         for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
            @(negedge clk);
            chk("rnd_hold", result, ref_div(a, b, sgn, wr));
         end
         release_out("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
